fetch_sequencer: RTL and testbench

Instruction-byte fetch controller that feeds the decode stage of the 8-bit core. It holds the PC and issues in-order byte reads to instruction memory over a valid/ready request channel. Returned bytes are buffered in a credit-limited FIFO and presented to decode one byte per cycle. It tags the byte that follows an immediate-format opcode, honours the decode stall, and handles PC redirects by flushing and draining in-flight reads.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/byte_fifo.sv | 51 +++++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-byte fetch sequencer.
package fetch_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DEPTH  = 4;

   typedef enum logic [0:0] {
      RUN,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with wrapping pointers; clear overrides push and pop.
module byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   sync_rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             wdata,
   output logic [7:0]             rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [7:0]    storage [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (!sync_rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst && !clear && push) storage[wr_ptr] <= wdata;
   end

   always_comb begin
      rdata = storage[rd_ptr];
      empty = (count == '0);
      full  = (count == (PW+1)'(DEPTH));
   end

   assert property (@(posedge clk) disable iff (!sync_rst) !(pop && empty && !clear));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: PC, credit-limited in-order byte reads, decode-side FIFO,
// immediate-byte tagging and redirect flush/drain.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       DEPTH    = DEF_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              sync_rst,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [7:0]        mem_rsp_data,
   output logic [7:0]        opcode,
   output logic              opcode_valid,
   output logic              is_imm_byte,
   input  logic              stall_en,
   input  logic              dec_has_imm,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy_drain
);

   localparam int unsigned CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   fetch_state_e      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [CW-1:0]     outstanding, outstanding_next;
   logic [CW-1:0]     fifo_count;
   logic              imm_pending, imm_pending_next;
   logic              fifo_empty, fifo_full;
   logic              run, pop, req_fire, push, fifo_clear;
   logic [CW:0]       used, in_flight;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .sync_rst (sync_rst),
      .clear    (fifo_clear),
      .push     (push),
      .pop      (pop),
      .wdata    (mem_rsp_data),
      .rdata    (opcode),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // Outputs are forced idle while reset is held, independent of stored state.
   always_comb begin
      run           = (state == RUN) && sync_rst;
      opcode_valid  = run && !fifo_empty;
      pop           = opcode_valid && !stall_en;
      used          = {1'b0, outstanding} + {1'b0, fifo_count};
      mem_req_valid = run && ((used - {{CW{1'b0}}, pop}) < DEPTH_W);
      mem_req_addr  = pc;
      req_fire      = mem_req_valid && mem_req_ready;
      is_imm_byte   = imm_pending && opcode_valid;
      busy_drain    = sync_rst && (state == DRAIN);
      in_flight     = {1'b0, outstanding} + {{CW{1'b0}}, req_fire}
                      - {{CW{1'b0}}, mem_rsp_valid};
   end

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      outstanding_next = in_flight[CW-1:0];
      imm_pending_next = imm_pending;
      push             = mem_rsp_valid && (state == RUN);
      fifo_clear       = 1'b0;

      if (req_fire) pc_next = pc + 1'b1;

      if (pop) begin
         if (is_imm_byte) begin
            imm_pending_next = 1'b0;
         end else if (dec_has_imm) begin
            imm_pending_next = 1'b1;
         end
      end

      if (state == DRAIN && in_flight == '0) state_next = RUN;

      // A request accepted alongside the redirect is already in flight and gets drained.
      if (redirect_valid) begin
         pc_next          = redirect_pc;
         fifo_clear       = 1'b1;
         imm_pending_next = 1'b0;
         state_next       = (in_flight == '0) ? RUN : DRAIN;
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         imm_pending <= 1'b0;
      end else begin
         pc          <= pc_next;
         outstanding <= outstanding_next;
         imm_pending <= imm_pending_next;
      end
   end

   assert property (@(posedge clk) disable iff (!sync_rst)
                    !(mem_rsp_valid && outstanding == '0));
   assert property (@(posedge clk) disable iff (!sync_rst)
                    !(push && fifo_full && !fifo_clear));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-order, fixed-latency memory model.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       sync_rst = 1'b0;
   logic       mem_req_valid;
   logic [7:0] mem_req_addr;
   logic       mem_req_ready = 1'b1;
   logic       mem_rsp_valid = 1'b0;
   logic [7:0] mem_rsp_data = 8'h00;
   logic [7:0] opcode;
   logic       opcode_valid;
   logic       is_imm_byte;
   logic       stall_en = 1'b0;
   logic       dec_has_imm = 1'b0;
   logic       redirect_valid = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       busy_drain;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int lat      = 1;

   logic [7:0] q_addr [$];
   int         q_due  [$];

   typedef struct {
      logic       stall;
      logic       dimm;
      logic       redir;
      logic [7:0] rpc;
      logic       rv;
      logic [7:0] addr;
      logic       ov;
      logic [7:0] op;
      logic       imm;
      logic       busy;
   } vec_t;

   vec_t vec [26];

   fetch_sequencer #(
      .ADDR_W   (8),
      .DEPTH    (4),
      .RESET_PC (8'h00)
   ) dut (
      .clk            (clk),
      .sync_rst       (sync_rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .opcode         (opcode),
      .opcode_valid   (opcode_valid),
      .is_imm_byte    (is_imm_byte),
      .stall_en       (stall_en),
      .dec_has_imm    (dec_has_imm),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy_drain     (busy_drain)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   // Memory model: capture the pre-edge request, then present due responses after the edge.
   task automatic tick();
      logic       fire;
      logic [7:0] a;
      logic       in_rst;
      fire   = mem_req_valid && mem_req_ready;
      a      = mem_req_addr;
      in_rst = !sync_rst;
      @(posedge clk);
      #1;
      if (in_rst) begin
         q_addr.delete();
         q_due.delete();
      end else if (fire) begin
         q_addr.push_back(a);
         q_due.push_back(cyc + lat);
      end
      cyc++;
      mem_rsp_valid = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = q_addr[0] ^ 8'hA5;
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_valid"}, mem_req_valid, 1'b0);
      check({tag, "_opcode_valid"}, opcode_valid, 1'b0);
      check({tag, "_is_imm"}, is_imm_byte, 1'b0);
      check({tag, "_busy"}, busy_drain, 1'b0);
   endtask

   initial begin
      logic [7:0] exp_a;
      logic [7:0] fired [4];
      logic [7:0] exp_w [4];
      logic       prev_hold;
      logic [7:0] prev_addr;
      logic       got_op;
      int         nf;

      // stall dimm redir rpc | rv addr ov op imm busy  (mem[a] = a ^ A5)
      vec[0]  = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0};
      vec[1]  = '{0, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0, 0};
      vec[2]  = '{0, 0, 0, 8'h00, 1, 8'h02, 1, 8'hA5, 0, 0};
      vec[3]  = '{0, 0, 0, 8'h00, 1, 8'h03, 1, 8'hA4, 0, 0};
      vec[4]  = '{0, 0, 0, 8'h00, 1, 8'h04, 1, 8'hA7, 0, 0};
      vec[5]  = '{0, 0, 0, 8'h00, 1, 8'h05, 1, 8'hA6, 0, 0};
      vec[6]  = '{0, 0, 0, 8'h00, 1, 8'h06, 1, 8'hA1, 0, 0};
      vec[7]  = '{0, 1, 0, 8'h00, 1, 8'h07, 1, 8'hA0, 0, 0};
      vec[8]  = '{0, 1, 0, 8'h00, 1, 8'h08, 1, 8'hA3, 1, 0};
      vec[9]  = '{0, 0, 0, 8'h00, 1, 8'h09, 1, 8'hA2, 0, 0};
      vec[10] = '{0, 0, 0, 8'h00, 1, 8'h0A, 1, 8'hAD, 0, 0};
      vec[11] = '{0, 0, 1, 8'hB7, 1, 8'h0B, 1, 8'hAC, 0, 0};
      vec[12] = '{0, 0, 0, 8'h00, 0, 8'hB7, 0, 8'h00, 0, 1};
      vec[13] = '{0, 0, 0, 8'h00, 1, 8'hB7, 0, 8'h00, 0, 0};
      vec[14] = '{0, 0, 0, 8'h00, 1, 8'hB8, 0, 8'h00, 0, 0};
      vec[15] = '{1, 0, 0, 8'h00, 1, 8'hB9, 1, 8'h12, 0, 0};
      vec[16] = '{1, 0, 0, 8'h00, 1, 8'hBA, 1, 8'h12, 0, 0};
      vec[17] = '{1, 0, 0, 8'h00, 0, 8'hBB, 1, 8'h12, 0, 0};
      vec[18] = '{1, 0, 0, 8'h00, 0, 8'hBB, 1, 8'h12, 0, 0};
      vec[19] = '{1, 0, 0, 8'h00, 0, 8'hBB, 1, 8'h12, 0, 0};
      vec[20] = '{0, 0, 0, 8'h00, 1, 8'hBB, 1, 8'h12, 0, 0};
      vec[21] = '{0, 0, 0, 8'h00, 1, 8'hBC, 1, 8'h1D, 0, 0};
      vec[22] = '{0, 0, 0, 8'h00, 1, 8'hBD, 1, 8'h1C, 0, 0};
      vec[23] = '{0, 0, 0, 8'h00, 1, 8'hBE, 1, 8'h1F, 0, 0};
      vec[24] = '{0, 0, 0, 8'h00, 1, 8'hBF, 1, 8'h1E, 0, 0};
      vec[25] = '{0, 0, 0, 8'h00, 1, 8'hC0, 1, 8'h19, 0, 0};

      // Reset state, then streaming, immediate tagging, redirect and stall.
      @(negedge clk);
      check_idle("reset");
      tick();
      tick();
      sync_rst = 1'b1;
      cyc      = 0;
      for (int i = 0; i < 26; i++) begin
         stall_en       = vec[i].stall;
         dec_has_imm    = vec[i].dimm;
         redirect_valid = vec[i].redir;
         redirect_pc    = vec[i].rpc;
         @(negedge clk);
         check($sformatf("v%0d_req_valid", i), mem_req_valid, vec[i].rv);
         check($sformatf("v%0d_addr", i), mem_req_addr, vec[i].addr);
         check($sformatf("v%0d_opcode_valid", i), opcode_valid, vec[i].ov);
         if (vec[i].ov) check($sformatf("v%0d_opcode", i), opcode, vec[i].op);
         check($sformatf("v%0d_is_imm", i), is_imm_byte, vec[i].imm);
         check($sformatf("v%0d_busy", i), busy_drain, vec[i].busy);
         tick();
      end
      stall_en       = 1'b0;
      dec_has_imm    = 1'b0;
      redirect_valid = 1'b0;

      // Latency 3: redirect with two reads outstanding plus a same-cycle accept.
      lat      = 3;
      sync_rst = 1'b0;
      @(negedge clk);
      check_idle("t4_reset");
      tick();
      sync_rst = 1'b1;
      cyc      = 0;
      @(negedge clk);
      check("t4_addr0", mem_req_addr, 8'h00);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      @(negedge clk);
      check("t4_fire_with_redirect", mem_req_valid, 1'b1);
      tick();
      redirect_valid = 1'b0;
      for (int c = 3; c < 12; c++) begin
         @(negedge clk);
         exp_a = (c < 6) ? 8'h40 : 8'(8'h40 + c - 6);
         check($sformatf("t4_c%0d_busy", c), busy_drain, (c <= 5));
         check($sformatf("t4_c%0d_req_valid", c), mem_req_valid, (c >= 6));
         check($sformatf("t4_c%0d_addr", c), mem_req_addr, exp_a);
         check($sformatf("t4_c%0d_opcode_valid", c), opcode_valid, (c >= 10));
         if (c >= 10) begin
            exp_a = 8'(8'h40 + c - 10) ^ 8'hA5;
            check($sformatf("t4_c%0d_opcode", c), opcode, exp_a);
         end
         tick();
      end

      // Reset held for one cycle while draining.
      redirect_valid = 1'b1;
      redirect_pc    = 8'h80;
      @(negedge clk);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("t6_in_drain", busy_drain, 1'b1);
      tick();
      sync_rst = 1'b0;
      @(negedge clk);
      check_idle("t6_reset");
      tick();
      sync_rst = 1'b1;
      cyc      = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp_a = 8'(c);
         check($sformatf("t6_c%0d_req_valid", c), mem_req_valid, 1'b1);
         check($sformatf("t6_c%0d_addr", c), mem_req_addr, exp_a);
         check($sformatf("t6_c%0d_opcode_valid", c), opcode_valid, (c == 4));
         if (c == 4) check("t6_first_opcode", opcode, 8'hA5);
         tick();
      end

      // PC wrap after redirect to 0xFE, with ready gaps to check request hold.
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFE;
      @(negedge clk);
      tick();
      redirect_valid = 1'b0;
      nf        = 0;
      got_op    = 1'b0;
      prev_hold = 1'b0;
      prev_addr = 8'h00;
      for (int k = 0; k < 40 && (nf < 4 || !got_op); k++) begin
         mem_req_ready = (k % 3 != 1);
         @(negedge clk);
         if (prev_hold) begin
            check($sformatf("t5_hold%0d_valid", k), mem_req_valid, 1'b1);
            check($sformatf("t5_hold%0d_addr", k), mem_req_addr, prev_addr);
         end
         prev_hold = mem_req_valid && !mem_req_ready;
         prev_addr = mem_req_addr;
         if (mem_req_valid && mem_req_ready && nf < 4) begin
            fired[nf] = mem_req_addr;
            nf++;
         end
         if (opcode_valid && !got_op) begin
            got_op = 1'b1;
            check("t5_first_opcode", opcode, 8'h5B);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      exp_w[0] = 8'hFE;
      exp_w[1] = 8'hFF;
      exp_w[2] = 8'h00;
      exp_w[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         if (i < nf) begin
            check($sformatf("t5_wrap_addr%0d", i), fired[i], exp_w[i]);
         end else begin
            expire($sformatf("t5_wrap_addr%0d", i));
         end
      end
      if (!got_op) expire("t5_first_opcode");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
